io_bridge: RTL

Memory-bus bridge between the CPU's byte bus and the RAM and UART. It decodes each CPU access into RAM or I/O: addresses with `mem_a[17:16]==2'b11` are I/O, everything else is RAM. It buffers UART output bytes in a transmit FIFO and drives `io_buffer_full` back to the CPU. It also provides the free-running cycle counter and signals program stop.

---
 rtl/io_bridge_pkg.sv | 12 +
 rtl/io_tx_fifo.sv | 44 ++++
 rtl/io_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/io_bridge_pkg.sv
// Shared decode constants and read-source encoding for the CPU/RAM/UART bridge.
package io_bridge_pkg;
  localparam logic [17:0] IO_PORT_ADDR = 18'h30000;
  localparam logic [17:0] IO_CNT_ADDR  = 18'h30004;
  localparam logic [1:0]  IO_SEL_BITS  = 2'b11;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_IO   = 2'd2
  } din_src_e;
endpackage

// File: rtl/io_tx_fifo.sv
// UART transmit FIFO; a push into a full FIFO is accepted only if a pop frees a slot
// in the same cycle, otherwise it is dropped and flagged on drop_o.
module io_tx_fifo #(
  parameter int TX_DEPTH = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        push_i,
  input  logic [7:0]                  wdata_i,
  input  logic                        pop_i,
  output logic [7:0]                  rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        drop_o,
  output logic [$clog2(TX_DEPTH):0]   count_o
);
  localparam int AW = $clog2(TX_DEPTH);

  logic [7:0]  mem_q [TX_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign rd_en   = pop_i & ~empty_o;
  assign wr_en   = push_i & (~full_o | rd_en);
  assign drop_o  = push_i & ~wr_en;
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/io_bridge.sv
// CPU byte-bus bridge: RAM/IO decode, UART TX FIFO, stop/done flags and cycle counter.
// Optional feature macro: IO_CYCLE_COUNTER_EN (cycle counter + snapshot reads).
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        prog_done,
  output logic        tx_overflow
);
  localparam int AW = $clog2(TX_DEPTH);

  logic [17:0] a18;
  logic        is_io, io_wr, io_rd, wr_port, wr_stop, push, pop;
  logic        fifo_full, fifo_empty, fifo_drop, full_d;
  logic [7:0]  push_data, io_d, io_q;
  logic [AW:0] fifo_cnt, cnt_nxt;
  logic        stop_q, done_q, ovf_q, bfull_q;
  din_src_e    src_q;
  logic        unused_addr_hi;

  assign a18            = cpu_a[17:0];
  assign unused_addr_hi = ^cpu_a[31:18];
  assign is_io          = (a18[17:16] == IO_SEL_BITS);

  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;
  assign ram_wr   = cpu_wr & ~is_io & rdy_in;

  assign io_wr     = rdy_in & is_io & cpu_wr & ~stop_q;
  assign io_rd     = rdy_in & is_io & ~cpu_wr;
  assign wr_port   = io_wr & (a18 == IO_PORT_ADDR) & (cpu_dout != 8'h00);
  assign wr_stop   = io_wr & (a18 == IO_CNT_ADDR);
  assign push      = wr_port | wr_stop;
  assign push_data = wr_stop ? 8'h00 : cpu_dout;

  assign tx_valid = ~fifo_empty;
  assign pop      = tx_valid & tx_ready;

  io_tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (fifo_cnt)
  );

  // Back-pressure looks at the occupancy after this cycle's push/pop.
  assign cnt_nxt = fifo_cnt + (AW+1)'(push & ~fifo_drop) - (AW+1)'(pop);
  assign full_d  = (32'(cnt_nxt) + 32'(FULL_MARGIN)) >= 32'(TX_DEPTH);

  assign rx_pop = rst_in & io_rd & (a18 == IO_PORT_ADDR) & rx_valid;

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, snap_q;
  logic        snap_ld;

  assign snap_ld = io_rd & (a18 == IO_CNT_ADDR);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cyc_q  <= '0;
      snap_q <= '0;
    end else begin
      if (rdy_in)  cyc_q  <= cyc_q + 32'd1;
      if (snap_ld) snap_q <= cyc_q;
    end
  end
`endif

  always_comb begin
    io_d = 8'h00;
    if (a18 == IO_PORT_ADDR) io_d = rx_valid ? rx_data : 8'h00;
`ifdef IO_CYCLE_COUNTER_EN
    else if (a18 == IO_CNT_ADDR)          io_d = cyc_q[7:0];
    else if (a18 == IO_CNT_ADDR + 18'd1)  io_d = snap_q[15:8];
    else if (a18 == IO_CNT_ADDR + 18'd2)  io_d = snap_q[23:16];
    else if (a18 == IO_CNT_ADDR + 18'd3)  io_d = snap_q[31:24];
`endif
  end

  always_comb begin
    case (src_q)
      SRC_RAM: cpu_din = ram_din;
      SRC_IO:  cpu_din = io_q;
      default: cpu_din = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bfull_q <= 1'b0;
      io_q    <= 8'h00;
      src_q   <= SRC_NONE;
    end else begin
      if (fifo_drop) ovf_q  <= 1'b1;
      if (wr_stop)   stop_q <= 1'b1;
      done_q  <= done_q | (stop_q & fifo_empty);
      bfull_q <= full_d;
      if (rdy_in) begin
        if (is_io) begin
          src_q <= SRC_IO;
          if (!cpu_wr) io_q <= io_d;
        end else begin
          src_q <= SRC_RAM;
        end
      end else begin
        // Stalled: freeze whatever the CPU currently sees, RAM data included.
        io_q  <= cpu_din;
        src_q <= SRC_IO;
      end
    end
  end

  assign prog_done      = done_q;
  assign tx_overflow    = ovf_q;
  assign io_buffer_full = bfull_q;
endmodule
